// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions for the register-shifted Val2 sequencer.
//   - Shift-type codes (Shift_operand[6:5]).
//   - Sequencer state encoding.
//   - Saturation limit for LSL/LSR/ASR.
//   - eff_count(): maps a type and Rs[7:0] to the number of bit positions
//     that must actually be shifted.
package exe_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Shifting by 33 already gives the architectural result for any larger
  // LSL/LSR/ASR amount, so larger counts are clamped to this value.
  localparam logic [5:0] SAT_AMT = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

  function automatic logic [5:0] eff_count(input logic [1:0] sh_type,
                                           input logic [7:0] amt);
    logic [5:0] eff;
    if (amt == 8'd0) begin
      eff = 6'd0;
    end else if (sh_type == SH_ROR) begin
      // A nonzero multiple of 32 is a full rotation: the value comes back
      // unchanged, but the carry still becomes bit 31.
      eff = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
    end else begin
      eff = (amt > 8'(SAT_AMT)) ? SAT_AMT : amt[5:0];
    end
    return eff;
  endfunction

endpackage

// File: rtl/val2_shift_seq_shift_step.sv
// shift_step: one combinational step of the Val2 shifter.
//   w          in   32  current work value
//   carry      in   1   current carry value
//   sh_type    in   2   LSL / LSR / ASR / ROR
//   k          in   6   positions to shift this step (0..STEP)
//   w_next     out  32  shifted work value
//   carry_next out  1   carry after this step (unchanged when k == 0)
module shift_step
  import exe_pkg::*;
(
  input  logic [31:0] w,
  input  logic        carry,
  input  logic [1:0]  sh_type,
  input  logic [5:0]  k,
  output logic [31:0] w_next,
  output logic        carry_next
);

  // 33-bit extended shifts put the last bit shifted out at a fixed position,
  // which avoids variable bit-select indices such as w[32-k].
  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [31:0] ror_val;

  assign lsl_ext = {1'b0, w} << k;
  assign lsr_ext = {w, 1'b0} >> k;
  assign asr_ext = 33'($signed({w, 1'b0}) >>> k);
  assign ror_val = (w >> k) | (w << (6'd32 - k));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next     = w;
    carry_next = carry;
    if (k != 6'd0) begin
      unique case (sh_type)
        SH_LSL: begin
          w_next     = lsl_ext[31:0];
          carry_next = lsl_ext[32];
        end
        SH_LSR: begin
          w_next     = lsr_ext[32:1];
          carry_next = lsr_ext[0];
        end
        SH_ASR: begin
          w_next     = asr_ext[32:1];
          carry_next = asr_ext[0];
        end
        SH_ROR: begin
          w_next     = ror_val;
          carry_next = ror_val[31];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_seq.sv
// val2_shift_seq: multi-cycle sequencer for register-specified shifts.
// It runs a STEP-bit-per-cycle shifter until the effective count is used up,
// then pulses done with the final Val2 and shifter carry-out.
//   clk        in   1   pipeline clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   request, honoured only in IDLE or DONE
//   flush      in   1   abort; forces IDLE, beats start
//   shift_type in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shift_amt  in   8   Rs[7:0]
//   val_rm     in   32  operand to shift
//   carry_in   in   1   current CPSR C
//   busy       out  1   high while shifting (stalls the front of the pipe)
//   done       out  1   one-cycle pulse when val2/carry_out are final
//   val2       out  32  result, held until the next accepted start
//   carry_out  out  1   shifter carry, held with val2
module val2_shift_seq
  import exe_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amt,
  input  logic [31:0] val_rm,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  localparam logic [5:0] STEP_K = 6'(STEP);

  seq_state_t  state, state_next;
  logic [31:0] w_q, w_next;
  logic        c_q, c_next;
  logic [1:0]  type_q;
  logic [5:0]  rem_q, rem_next, k, eff;
  logic        accept;

  assign eff      = eff_count(shift_type, shift_amt);
  assign accept   = start && !flush && (state == ST_IDLE || state == ST_DONE);
  assign k        = (rem_q > STEP_K) ? STEP_K : rem_q;
  assign rem_next = rem_q - k;

  shift_step u_step (
    .w          (w_q),
    .carry      (c_q),
    .sh_type    (type_q),
    .k          (k),
    .w_next     (w_next),
    .carry_next (c_next)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_next = (eff == 6'd0) ? ST_DONE : ST_SHIFT;
        else        state_next = ST_IDLE;
      end
      ST_SHIFT: if (rem_next == 6'd0) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values present before this edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      w_q    <= '0;
      c_q    <= 1'b0;
      type_q <= SH_LSL;
      rem_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        w_q    <= val_rm;
        c_q    <= carry_in;
        type_q <= shift_type;
        rem_q  <= eff;
      end else if (state == ST_SHIFT && !flush) begin
        // A flushed step is dropped; the partial value is left as is.
        w_q   <= w_next;
        c_q   <= c_next;
        rem_q <= rem_next;
      end
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign val2      = w_q;
  assign carry_out = c_q;

endmodule
